// File: rtl/fp_to_int.sv
// Pipelined IEEE 754 (fp16/fp32/fp64) to signed/unsigned integer converter.
// Three valid/ready stages: unpack, align with guard/round/sticky, then round/saturate.
module fp_to_int #(
  parameter int WIDTH = 16,
  parameter int INT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       rm,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] result,
  output logic             flag_invalid,
  output logic             flag_inexact
);

  localparam int EXP_W  = (WIDTH == 16) ? 5 : (WIDTH == 32) ? 8 : 11;
  localparam int MANT_W = WIDTH - 1 - EXP_W;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam int FB     = MANT_W + 2;
  localparam int DW     = INT_W + 1 + FB;

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;
  localparam logic [2:0] RMM = 3'd4;

  localparam logic [INT_W+1:0] SMAX_MAG = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic [INT_W+1:0] SMIN_MAG = {3'b001, {(INT_W-1){1'b0}}};

  function automatic logic round_inc(input logic [2:0] mode, input logic neg,
                                     input logic l, input logic g,
                                     input logic r, input logic s);
    case (mode)
      RTZ:     round_inc = 1'b0;
      RDN:     round_inc = neg & (g | r | s);
      RUP:     round_inc = ~neg & (g | r | s);
      RMM:     round_inc = g;
      default: round_inc = g & (r | s | l);
    endcase
  endfunction

  function automatic logic out_of_range(input logic [INT_W+1:0] mag, input logic neg,
                                        input logic sgn);
    if (sgn) out_of_range = neg ? (mag > SMIN_MAG) : (mag > SMAX_MAG);
    else     out_of_range = neg ? (mag != '0) : (|mag[INT_W+1:INT_W]);
  endfunction

  logic vld_p1, vld_p2, vld_p3;
  logic ld1, ld2, ld3;

  assign ld3       = !vld_p3 || out_ready;
  assign ld2       = !vld_p2 || ld3;
  assign ld1       = !vld_p1 || ld2;
  assign in_ready  = ld1;
  assign out_valid = vld_p3;

  // Stage 1: unpack and classify
  logic              sign_in;
  logic [EXP_W-1:0]  exp_in;
  logic [MANT_W-1:0] frac_in;
  assign {sign_in, exp_in, frac_in} = a;

  logic              sign_p1, nan_p1, inf_p1, sgn_p1;
  logic [2:0]        rm_p1;
  logic [EXP_W-1:0]  exp_p1;
  logic [MANT_W:0]   sig_p1;

  // Stage 2: align to integer with guard/round/sticky
  logic [DW-1:0]     d, d2;
  logic              lost, ovf_c;
  int                ei, k;

  always_comb begin
    d     = {{INT_W{1'b0}}, sig_p1, 2'b00};
    d2    = '0;
    lost  = 1'b0;
    ovf_c = 1'b0;
    ei    = int'({1'b0, exp_p1}) - BIAS;
    k     = -ei;
    if (ei >= 0) begin
      if (ei > INT_W) ovf_c = 1'b1;
      else            d2 = d << ei;
    end else if (k >= DW) begin
      lost = |d;
    end else begin
      d2   = d >> k;
      lost = ((d2 << k) != d);
    end
  end

  logic              sign_p2, nan_p2, inf_p2, sgn_p2, ovf_p2, g_p2, r_p2, s_p2;
  logic [2:0]        rm_p2;
  logic [INT_W:0]    mag_p2;

  // Stage 3: round, range-check, saturate, negate
  logic [INT_W+1:0]  rnd;
  logic [INT_W-1:0]  maxv, minv, res_c;
  logic              inv_c, inx_c, grs;

  always_comb begin
    grs   = g_p2 | r_p2 | s_p2;
    rnd   = {1'b0, mag_p2} +
            {{(INT_W+1){1'b0}}, round_inc(rm_p2, sign_p2, mag_p2[0], g_p2, r_p2, s_p2)};
    maxv  = sgn_p2 ? {1'b0, {(INT_W-1){1'b1}}} : {INT_W{1'b1}};
    minv  = sgn_p2 ? {1'b1, {(INT_W-1){1'b0}}} : {INT_W{1'b0}};
    inv_c = nan_p2 | inf_p2 | ovf_p2 | out_of_range(rnd, sign_p2, sgn_p2);
    inx_c = grs & ~inv_c;
    if (nan_p2)       res_c = maxv;
    else if (inv_c)   res_c = sign_p2 ? minv : maxv;
    else if (sign_p2) res_c = -rnd[INT_W-1:0];
    else              res_c = rnd[INT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      vld_p3       <= 1'b0;
      result       <= '0;
      flag_invalid <= 1'b0;
      flag_inexact <= 1'b0;
    end else begin
      if (ld1) vld_p1 <= in_valid;
      if (ld2) vld_p2 <= vld_p1;
      if (ld3) vld_p3 <= vld_p2;
      if (ld3 && vld_p2) begin
        result       <= res_c;
        flag_invalid <= inv_c;
        flag_inexact <= inx_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld1) begin
      sign_p1 <= sign_in;
      nan_p1  <= (&exp_in) && (frac_in != '0);
      inf_p1  <= (&exp_in) && (frac_in == '0);
      exp_p1  <= (exp_in == '0) ? {{(EXP_W-1){1'b0}}, 1'b1} : exp_in;
      sig_p1  <= {exp_in != '0, frac_in};
      rm_p1   <= rm;
      sgn_p1  <= is_signed;
    end
    if (ld2) begin
      sign_p2 <= sign_p1;
      nan_p2  <= nan_p1;
      inf_p2  <= inf_p1;
      sgn_p2  <= sgn_p1;
      rm_p2   <= rm_p1;
      ovf_p2  <= ovf_c;
      mag_p2  <= d2[DW-1:FB];
      g_p2    <= d2[FB-1];
      r_p2    <= d2[FB-2];
      s_p2    <= (|d2[FB-3:0]) | lost;
    end
  end

endmodule

// File: doc/fp_to_int.md
Name: fp_to_int

Overview:
- Pipelined IEEE 754 float-to-integer converter.
- Consumes packed fp16/fp32/fp64 values, such as those produced by the fp adder datapath, and returns a signed or unsigned two's-complement integer.
- Supports the shared `RNE`/`RTZ`/`RDN`/`RUP`/`RMM` rounding-mode encoding from grs_round.vh.
- Uses a three-stage valid/ready pipeline with full backpressure. It sits between the FP unit result bus and integer consumers such as register writeback and address generation.

Parameters:
- WIDTH, 16, float width: 16, 32 or 64. EXP_W, bias and MANT_W follow IEEE 754.
- INT_W, 32, integer result width. Legal values are 8 to 64.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- a  in  WIDTH  packed float operand.
- rm  in  3  rounding mode, `RNE`/`RTZ`/`RDN`/`RUP`/`RMM` per grs_round.vh.
- is_signed  in  1  1 = signed INT_W result, 0 = unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted when out_valid && out_ready.
- result  out  INT_W  converted integer.
- flag_invalid  out  1  NaN, Inf, or out-of-range source.
- flag_inexact  out  1  result differs from the source and flag_invalid = 0.

Behaviour:
- Reset is synchronous: at the rst edge all stage valids go to 0. This drops any in-flight beats with no output.
  - Reset values: out_valid = 0, result = 0, flags = 0.
  - in_ready = 1 in the cycle after reset releases.
- Pipeline stages:
  - S1 unpacks and classifies the operand (zero, denormal, normal, inf, NaN) and forms the significand with its implicit bit. The implicit bit is 0 for denormals, which use exponent 1 - bias.
  - S2 computes unbiased e = exp - bias. If e >= 0, the significand is shifted left by e. Otherwise it is shifted right, collecting guard, round and sticky bits. The pre-round magnitude is held at INT_W+1 bits, plus an overflow-sticky bit for e >= INT_W+1.
  - S3 rounds the magnitude, negates it if the sign is 1, checks range, saturates, and registers result and flags.
- Latency is 3 cycles from accept to out_valid with no stall. Throughput is one beat per cycle.
- Handshake:
  - Each stage register loads when it is empty or its downstream stage loads that cycle.
  - The S3 output drains when out_ready = 1.
  - in_ready = !s1_valid || s1 advances. It is combinational from out_ready through the stage valids.
  - While out_valid = 1 and out_ready = 0, result and flags hold stable.
  - Once the 3 stages are full, in_ready = 0. No beat is ever lost or reordered.
  - Simultaneous drain and accept in a full pipe sustains one beat per cycle.
- Rounding (G = guard bit, R = round bit, S = sticky bit, L = integer LSB):
  - `RNE`: increment if G && (R || S || L).
  - `RTZ`: never increment.
  - `RDN`: increment magnitude if sign && (G || R || S).
  - `RUP`: increment magnitude if !sign && (G || R || S).
  - `RMM`: increment if G.
  - Any reserved rm value is treated as `RNE`.
- Range after rounding:
  - Signed: valid range is -2^(INT_W-1) to 2^(INT_W-1)-1.
  - Unsigned: valid range is 0 to 2^INT_W-1.
  - Rounding carry-out is included in the range check.
- Special cases (set flag_invalid = 1, flag_inexact = 0):
  - NaN gives the signed max (0x7FFF…) or the unsigned max (all ones).
  - +Inf, and positive overflow, give the max value.
  - -Inf, and negative overflow, give the signed min (0x8000…) or, when unsigned, 0.
  - Unsigned with a negative source whose rounded magnitude is nonzero gives 0.
- Zero handling:
  - ±0 gives 0 with no flags.
  - A negative source that rounds to magnitude 0 under unsigned conversion gives 0, flag_inexact = 1, flag_invalid = 0.
- flag_inexact = 1 iff (G || R || S) and flag_invalid = 0.
- is_signed and rm are captured with the operand and travel with it through the pipeline. They may change every beat.

Test Plan:
- WIDTH=16, INT_W=32, signed. a=0x3E00 (1.5): `RNE` gives 2, `RTZ` gives 1, `RUP` gives 2, `RDN` gives 1. flag_inexact=1 in all four cases.
- a=0xC100 (-2.5), signed: `RNE` gives 0xFFFFFFFE, `RDN` gives 0xFFFFFFFD, `RMM` gives 0xFFFFFFFD, `RTZ` gives 0xFFFFFFFE. flag_inexact=1 in all four cases.
- Exact and tiny values:
  - a=0x7BFF (65504), signed, INT_W=32: result 0x0000FFE0, no flags.
  - Same a with INT_W=16: result 0x7FFF, flag_invalid=1.
  - a=0x0001 (denormal): `RUP` gives 1, `RNE` gives 0, flag_inexact=1 in both cases.
- Special and unsigned cases:
  - a=0x7C00 (+Inf), signed: result 0x7FFFFFFF, flag_invalid=1.
  - a=0x7E00 (NaN), unsigned: result 0xFFFFFFFF, flag_invalid=1.
  - a=0xBC00 (-1.0), unsigned: result 0, flag_invalid=1.
  - a=0xB400 (-0.25), unsigned, `RTZ`: result 0, flag_inexact=1.
- Backpressure: stream 6 beats of 1.0 to 6.0 (0x3C00, 0x4000, …) with out_ready=0 for 5 cycles, then out_ready=1.
  - in_ready must deassert after 3 accepts.
  - Outputs must be 1..6 in order with no duplicates.
  - result must be stable while stalled.
  - Then drive in_valid=out_ready=1 continuously and check one result per cycle at latency 3.
- Reset: assert rst for 1 cycle with 2 beats in flight. No stale out_valid may appear afterwards, and the first post-reset beat emerges 3 cycles after its accept.
